// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, fixed latency.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies finish one edge after start.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   acc_q;    // {hi, lo} product or {remainder, quotient}
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;    // sign of the selected output
  logic                early_q;

  logic                is_div, a_signed, b_signed, sa, sb, start_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       add_sum, shifted, diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_val;
  logic                special;
  logic [XLEN-1:0]     special_val;

  always_comb begin
    is_div    = funct3[2];
    a_signed  = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    b_signed  = funct3[2] ? !funct3[0] : !funct3[1];
    sa        = a_signed & op_a[XLEN-1];
    sb        = b_signed & op_b[XLEN-1];
    mag_a     = sa ? -op_a : op_a;
    mag_b     = sb ? -op_b : op_b;
    // A zero divisor yields an all-ones quotient, which must never be negated.
    if (is_div)
      start_neg = funct3[1] ? sa : ((sa ^ sb) && (op_b != '0));
    else
      start_neg = sa ^ sb;
  end

  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, acc_q[XLEN-1:1]};
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = shifted - {1'b0, opnd_q};
    div_next = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo_fix;
      default:                final_val = rem_fix;
    endcase
    if (early_q)
      final_val = acc_q[XLEN-1:0];
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic div_zero, div_ovf, mul_zero;
  always_comb begin
    div_zero    = is_div && (op_b == '0);
    div_ovf     = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    mul_zero    = !is_div && ((op_a == '0) || (op_b == '0));
    special     = div_zero || div_ovf || mul_zero;
    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? op_a : '1;
    else if (div_ovf)
      special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  always_comb begin
    special     = 1'b0;
    special_val = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= funct3;
            cnt_q <= '0;
            if (special) begin
              acc_q   <= {{XLEN{1'b0}}, special_val};
              neg_q   <= 1'b0;
              early_q <= 1'b1;
              state   <= FINISH;
            end else begin
              opnd_q  <= is_div ? mag_b : mag_a;
              acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              neg_q   <= start_neg;
              early_q <= 1'b0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1))
              state <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            result <= final_val;
            done   <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, latency, flush/reset aborts, back-to-back issue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_EDGES = 1;
  localparam int SPECIAL_BUSY  = 0;
`else
  localparam int SPECIAL_EDGES = 33;
  localparam int SPECIAL_BUSY  = 33;
`endif

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Drive one request; returns at the negedge right after the start edge.
  task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // edges counts posedges after the start edge until done is seen (start edge itself excluded).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int edges, output int busy_cyc);
    logic got;
    issue_op(f, a, b);
    edges = -1; busy_cyc = 0; got = 1'b0; res = '0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (done) begin
        got = 1'b1; edges = k; res = result;
      end else begin
        if (busy) busy_cyc++;
        @(negedge clk);
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL timeout f=%b a=%h b=%h: no done within 100 cycles", f, a, b);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b exp 0", busy); end
  endtask

  task automatic test_mul();
    logic [2:0]  f_t[5];
    logic [31:0] a_t[5], b_t[5], e_t[5];
    logic [31:0] res;
    int edges, bc;
    f_t[0] = 3'b000; a_t[0] = 32'd7;        b_t[0] = 32'hFFFFFFFD; e_t[0] = 32'hFFFFFFEB;
    f_t[1] = 3'b011; a_t[1] = 32'hFFFFFFFF; b_t[1] = 32'hFFFFFFFF; e_t[1] = 32'hFFFFFFFE;
    f_t[2] = 3'b001; a_t[2] = 32'hFFFFFFFF; b_t[2] = 32'hFFFFFFFF; e_t[2] = 32'h00000000;
    f_t[3] = 3'b010; a_t[3] = 32'hFFFFFFFF; b_t[3] = 32'hFFFFFFFF; e_t[3] = 32'hFFFFFFFF;
    f_t[4] = 3'b001; a_t[4] = 32'h80000000; b_t[4] = 32'h00000002; e_t[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, edges, bc);
      n_checks++;
      if (res !== e_t[i]) begin
        n_fail++; $display("FAIL mul_vec%0d f=%b: got %h exp %h", i, f_t[i], res, e_t[i]);
      end
      if (i == 0) begin
        // 33 edges after the start edge = 34 edges including it.
        n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d exp 33", edges); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d exp 33", bc); end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f_t[6];
    logic [31:0] a_t[6], b_t[6], e_t[6];
    logic [31:0] res;
    int edges, bc;
    f_t[0] = 3'b100; a_t[0] = 32'hFFFFFFF9; b_t[0] = 32'd2; e_t[0] = 32'hFFFFFFFD;
    f_t[1] = 3'b110; a_t[1] = 32'hFFFFFFF9; b_t[1] = 32'd2; e_t[1] = 32'hFFFFFFFF;
    f_t[2] = 3'b101; a_t[2] = 32'hFFFFFFF9; b_t[2] = 32'd2; e_t[2] = 32'h7FFFFFFC;
    f_t[3] = 3'b111; a_t[3] = 32'hFFFFFFF9; b_t[3] = 32'd2; e_t[3] = 32'h00000001;
    f_t[4] = 3'b100; a_t[4] = 32'd100;      b_t[4] = 32'hFFFFFFF9; e_t[4] = 32'hFFFFFFF2;
    f_t[5] = 3'b110; a_t[5] = 32'd100;      b_t[5] = 32'hFFFFFFF9; e_t[5] = 32'h00000002;
    for (int i = 0; i < 6; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, edges, bc);
      n_checks++;
      if (res !== e_t[i]) begin
        n_fail++; $display("FAIL div_vec%0d f=%b: got %h exp %h", i, f_t[i], res, e_t[i]);
      end
      if (i == 0) begin
        n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL div_latency: got %0d exp 33", edges); end
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f_t[7];
    logic [31:0] a_t[7], b_t[7], e_t[7];
    logic [31:0] res;
    int edges, bc;
    f_t[0] = 3'b101; a_t[0] = 32'h1234;     b_t[0] = 32'h0;        e_t[0] = 32'hFFFFFFFF;
    f_t[1] = 3'b111; a_t[1] = 32'h1234;     b_t[1] = 32'h0;        e_t[1] = 32'h00001234;
    f_t[2] = 3'b100; a_t[2] = 32'hFFFFFFFB; b_t[2] = 32'h0;        e_t[2] = 32'hFFFFFFFF;
    f_t[3] = 3'b110; a_t[3] = 32'hFFFFFFFB; b_t[3] = 32'h0;        e_t[3] = 32'hFFFFFFFB;
    f_t[4] = 3'b100; a_t[4] = 32'h80000000; b_t[4] = 32'hFFFFFFFF; e_t[4] = 32'h80000000;
    f_t[5] = 3'b110; a_t[5] = 32'h80000000; b_t[5] = 32'hFFFFFFFF; e_t[5] = 32'h00000000;
    f_t[6] = 3'b011; a_t[6] = 32'h0;        b_t[6] = 32'hFFFFFFFF; e_t[6] = 32'h00000000;
    for (int i = 0; i < 7; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, edges, bc);
      n_checks++;
      if (res !== e_t[i]) begin
        n_fail++; $display("FAIL special_vec%0d f=%b: got %h exp %h", i, f_t[i], res, e_t[i]);
      end
      if (i == 0 || i == 4) begin
        n_checks++;
        if (edges !== SPECIAL_EDGES) begin
          n_fail++; $display("FAIL special_latency%0d: got %0d exp %0d", i, edges, SPECIAL_EDGES);
        end
        n_checks++;
        if (bc !== SPECIAL_BUSY) begin
          n_fail++; $display("FAIL special_busy%0d: got %0d exp %0d", i, bc, SPECIAL_BUSY);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int edges, bc, dones;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, edges, bc);
    issue_op(3'b101, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b exp 0", busy); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d exp 0", dones); end
    n_checks++; if (result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL flush_result: got %h exp FFFFFFEB", result); end
    // flush in IDLE blocks a simultaneous start.
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b exp 0", busy); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL flush_idle_done: got %0d exp 0", dones); end
  endtask

  task automatic test_reset_mid();
    int dones;
    issue_op(3'b101, 32'd5000, 32'd3);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h exp 0", result); end
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d exp 0", dones); end
  endtask

  task automatic test_start_busy();
    int dones, first_k;
    logic [31:0] res;
    issue_op(3'b000, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first_k = -1; res = '0;
    for (int k = 5; k < 100; k++) begin
      if (done) begin
        dones++;
        if (first_k < 0) begin first_k = k; res = result; end
      end
      @(negedge clk);
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d exp 1", dones); end
    n_checks++; if (first_k !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d exp 33", first_k); end
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL busy_start_result: got %h exp 0000002a", res); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f_t[3];
    logic [31:0] a_t[3], b_t[3];
    logic [31:0] exp_v;
    int next, dones, last_c;
    f_t[0] = 3'b000; a_t[0] = 32'h00010000; b_t[0] = 32'h00010000;
    f_t[1] = 3'b011; a_t[1] = 32'h00010000; b_t[1] = 32'h00010000;
    f_t[2] = 3'b111; a_t[2] = 32'd17;       b_t[2] = 32'd5;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h00000002);
    @(negedge clk);
    funct3 = f_t[0]; op_a = a_t[0]; op_b = b_t[0]; start = 1'b1;
    next = 1; dones = 0; last_c = -1;
    for (int c = 0; c < 200 && dones < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        n_checks++;
        if (result !== exp_v) begin n_fail++; $display("FAIL b2b_result%0d: got %h exp %h", dones, result, exp_v); end
        if (dones > 0) begin
          n_checks++;
          if (c - last_c !== 34) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d exp 34", dones, c - last_c); end
        end
        last_c = c;
        dones++;
        if (next < 3) begin
          funct3 = f_t[next]; op_a = a_t[next]; op_b = b_t[next]; start = 1'b1;
          next++;
        end
      end
    end
    n_checks++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d exp 3", dones); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the M-extension operation (funct3 of an R-type instruction with funct7 = 0000001) and two register operands.
- Produces a 32-bit result after a fixed multi-cycle latency.
- Asserts busy so the hazard/pipeline logic stalls fetch and decode until done.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- flush  in  1  abort the in-flight operation (branch/jump redirect).
- funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- op_a  in  XLEN  rs1 value (multiplicand / dividend).
- op_b  in  XLEN  rs2 value (multiplier / divisor).
- busy  out  1  operation in flight; drives pipeline stall.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  registered result; held until the next done.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state = IDLE; busy, done = 0; result = 0; counter = 0; internal registers cleared.
  - Reset wins over start and flush in the same cycle.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FINISH.
- IDLE, start = 1 at edge N:
  - Latch funct3.
  - Latch operand magnitudes; signed operands are op_a for mul/mulh/mulhsu/div/rem and op_b for mul/mulh/div/rem.
  - Record result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - counter = 0, busy = 1, go to CALC.
- CALC, edges N+1..N+32: one iteration per edge, counter increments; leave CALC when counter = XLEN-1 at the edge.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FINISH, edge N+33:
  - Apply sign correction (two's complement negate if sign set).
  - Select output: low half (mul), high half (mulh/mulhsu/mulhu), quotient (div/divu), remainder (rem/remu); write result.
  - done = 1 for exactly one cycle, busy = 0, go to IDLE.
- Total latency: start edge to done = 34 edges; busy high for 33 cycles.
- Divide by zero (op_b = 0): quotient = 0xFFFFFFFF for div and divu; remainder = op_a for rem and remu. No exception.
- Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): div = 0x80000000, rem = 0.
- Without the optional feature, special cases complete with the normal 34-edge latency.
- start while busy: ignored, no queuing.
- start in the same cycle as done: accepted, since the state is already IDLE; back-to-back throughput is 1 operation per 34 cycles.
- flush:
  - In CALC or FINISH: return to IDLE next edge, busy = 0, no done, result unchanged.
  - In IDLE: blocks start in that cycle.
  - flush and start in the same cycle: flush wins.
- All widths exact: no truncation before the final select; the negate uses the full 2*XLEN width for the mulh variants.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: divide by zero, signed overflow, and any multiply with op_a = 0 or op_b = 0 skip CALC.
  - The special result is computed in IDLE and written at edge N+1.
  - done pulses the cycle after edge N+1; busy is never asserted.
- Undefined: every operation takes the full 34-edge latency; the special-case values are still exactly as above.

Test Plan:
- mul, op_a = 7, op_b = 0xFFFFFFFD (-3) -> done 34 edges after start; result = 0xFFFFFFEB; busy high 33 cycles.
- mulhu, op_a = op_b = 0xFFFFFFFF -> result = 0xFFFFFFFE. mulh with the same operands -> result = 0x00000000.
- div, op_a = 0xFFFFFFF9 (-7), op_b = 2 -> div result = 0xFFFFFFFD. rem with the same operands -> result = 0xFFFFFFFF.
- divu, op_b = 0, op_a = 0x1234 -> result = 0xFFFFFFFF. remu with the same operands -> result = 0x00001234.
- div, op_a = 0x80000000, op_b = 0xFFFFFFFF -> result = 0x80000000.
  - With MULDIV_EARLY_OUT_EN: done one edge after start, busy never high.
- Abort/ignore cases, each with result checked equal to its prior value (initially 0 after reset):
  - flush at edge N+10 of a divu -> busy low at N+11, no done.
  - rst_n = 0 at edge N+20 -> same as flush, and result = 0.
  - start pulsed at N+5 while busy -> ignored; exactly one done for the original operation.
